// File: rtl/sht40_measure_ctrl_if.sv
// Byte-operation channel between the SHT40 sequencer (master) and the I2C byte engine (slave).
interface sht40_measure_ctrl_if;
  logic       Op_Valid;
  logic [2:0] Op_Code;
  logic [7:0] Op_Data;
  logic       Op_Done;
  logic       Op_Nack;
  logic [7:0] Op_Rx_Data;

  modport master (output Op_Valid, Op_Code, Op_Data,
                  input  Op_Done, Op_Nack, Op_Rx_Data);
  modport slave  (input  Op_Valid, Op_Code, Op_Data,
                  output Op_Done, Op_Nack, Op_Rx_Data);
endinterface

// File: rtl/sht40_measure_ctrl.sv
// SHT40 single-shot high-precision measurement sequencer driving an I2C byte engine.
// Define SHT40_CRC_CHECK_EN to verify the CRC-8 of both words before reporting Done.
module sht40_measure_ctrl #(
  parameter logic [6:0]  DEV_ADDR    = 7'h44,
  parameter logic [7:0]  MEAS_CMD    = 8'hFD,
  parameter int unsigned WAIT_CYCLES = 480000,
  parameter int unsigned RETRY_MAX   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Meas_Start,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [1:0]  Err_Code,
  output logic [15:0] Temp_Raw,
  output logic [15:0] Hum_Raw,
  sht40_measure_ctrl_if.master bus
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int RW = ($clog2(RETRY_MAX + 1) > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
  localparam logic [RW-1:0] RMAX      = RW'(RETRY_MAX);

  localparam logic [2:0] OP_START = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_RDA   = 3'b010;
  localparam logic [2:0] OP_RDN   = 3'b011;
  localparam logic [2:0] OP_STOP  = 3'b100;

  typedef enum logic [3:0] {
    IDLE, W_START, W_ADDR, W_CMD, W_STOP, WAIT, R_START, R_ADDR,
    R_BYTE, R_STOP, CHECK, N_STOP
  } state_e;

  state_e        state_q, state_d;
  logic          op_valid_q, op_valid_d;
  logic [2:0]    op_code_q, op_code_d;
  logic [7:0]    op_data_q, op_data_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [15:0]   temp_q, temp_d, hum_q, hum_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [2:0]    idx_q, idx_d;
  logic [47:0]   rxbuf_q, rxbuf_d;
  logic [1:0]    nack_code_q, nack_code_d;
  logic          nack_rd_q, nack_rd_d;
  logic          req_op, op_fire;
  logic [2:0]    req_code;
  logic [7:0]    req_data;
`ifdef SHT40_CRC_CHECK_EN
  logic [7:0]    crc_t_q, crc_t_d, crc_h_q, crc_h_d, crc_t_n, crc_h_n;
  logic [3:0]    crc_cnt_q, crc_cnt_d;
  logic [15:0]   t_w, h_w;

  // One MSB-first bit of CRC-8, poly 0x31.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    crc_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h31 : 8'h00);
  endfunction
`endif

  assign op_fire = op_valid_q && bus.Op_Done;

  always_comb begin
    state_d     = state_q;
    op_valid_d  = op_valid_q;
    op_code_d   = op_code_q;
    op_data_d   = op_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    temp_d      = temp_q;
    hum_d       = hum_q;
    retry_d     = retry_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    rxbuf_d     = rxbuf_q;
    nack_code_d = nack_code_q;
    nack_rd_d   = nack_rd_q;
`ifdef SHT40_CRC_CHECK_EN
    crc_t_d     = crc_t_q;
    crc_h_d     = crc_h_q;
    crc_cnt_d   = crc_cnt_q;
    t_w         = rxbuf_q[47:32];
    h_w         = rxbuf_q[23:8];
    crc_t_n     = crc_step(crc_t_q, t_w[~crc_cnt_q]);
    crc_h_n     = crc_step(crc_h_q, h_w[~crc_cnt_q]);
`endif

    req_op   = 1'b1;
    req_code = OP_START;
    req_data = 8'h00;
    case (state_q)
      W_START, R_START:        req_code = OP_START;
      W_ADDR: begin            req_code = OP_WRITE; req_data = {DEV_ADDR, 1'b0}; end
      W_CMD:  begin            req_code = OP_WRITE; req_data = MEAS_CMD; end
      R_ADDR: begin            req_code = OP_WRITE; req_data = {DEV_ADDR, 1'b1}; end
      R_BYTE:                  req_code = (idx_q == 3'd5) ? OP_RDN : OP_RDA;
      W_STOP, R_STOP, N_STOP:  req_code = OP_STOP;
      default:                 req_op   = 1'b0;
    endcase

    // A state's op is raised one cycle after entry, which yields the idle gap between ops.
    if (req_op && !op_valid_q) begin
      op_valid_d = 1'b1;
      op_code_d  = req_code;
      op_data_d  = req_data;
    end
    if (op_fire) op_valid_d = 1'b0;

    case (state_q)
      IDLE: if (Meas_Start && !done_q && !err_q) begin
        busy_d     = 1'b1;
        err_code_d = 2'b00;
        retry_d    = '0;
        state_d    = W_START;
      end
      W_START: if (op_fire) state_d = W_ADDR;
      W_ADDR: if (op_fire) begin
        if (bus.Op_Nack) begin
          nack_code_d = 2'b01; nack_rd_d = 1'b0; state_d = N_STOP;
        end else state_d = W_CMD;
      end
      W_CMD: if (op_fire) begin
        if (bus.Op_Nack) begin
          nack_code_d = 2'b10; nack_rd_d = 1'b0; state_d = N_STOP;
        end else state_d = W_STOP;
      end
      W_STOP: if (op_fire) begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) state_d = R_START;
        else                     wait_d  = wait_q + WW'(1);
      end
      R_START: if (op_fire) state_d = R_ADDR;
      R_ADDR: if (op_fire) begin
        if (bus.Op_Nack) begin
          nack_code_d = 2'b01; nack_rd_d = 1'b1; state_d = N_STOP;
        end else begin
          idx_d   = 3'd0;
          state_d = R_BYTE;
        end
      end
      R_BYTE: if (op_fire) begin
        rxbuf_d = {rxbuf_q[39:0], bus.Op_Rx_Data};
        if (idx_q == 3'd5) state_d = R_STOP;
        else               idx_d   = idx_q + 3'd1;
      end
      R_STOP: if (op_fire) begin
        state_d = CHECK;
`ifdef SHT40_CRC_CHECK_EN
        crc_t_d   = 8'hFF;
        crc_h_d   = 8'hFF;
        crc_cnt_d = 4'd0;
`endif
      end
      CHECK: begin
`ifdef SHT40_CRC_CHECK_EN
        crc_t_d   = crc_t_n;
        crc_h_d   = crc_h_n;
        crc_cnt_d = crc_cnt_q + 4'd1;
        if (crc_cnt_q == 4'd15) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (crc_t_n == rxbuf_q[31:24] && crc_h_n == rxbuf_q[7:0]) begin
            temp_d = rxbuf_q[47:32];
            hum_d  = rxbuf_q[23:8];
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'b11;
          end
        end
`else
        temp_d  = rxbuf_q[47:32];
        hum_d   = rxbuf_q[23:8];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`endif
      end
      N_STOP: if (op_fire) begin
        if (retry_q < RMAX) begin
          retry_d = retry_q + RW'(1);
          // The sensor NACKs its read address while still converting, so only re-wait.
          if (nack_rd_q) begin
            wait_d  = '0;
            state_d = WAIT;
          end else state_d = W_START;
        end else begin
          err_d      = 1'b1;
          err_code_d = nack_code_q;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_valid_q  <= 1'b0;
      op_code_q   <= 3'b000;
      op_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      temp_q      <= 16'h0000;
      hum_q       <= 16'h0000;
      retry_q     <= '0;
      wait_q      <= '0;
      idx_q       <= 3'd0;
      rxbuf_q     <= 48'h0;
      nack_code_q <= 2'b00;
      nack_rd_q   <= 1'b0;
`ifdef SHT40_CRC_CHECK_EN
      crc_t_q     <= 8'hFF;
      crc_h_q     <= 8'hFF;
      crc_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      op_valid_q  <= op_valid_d;
      op_code_q   <= op_code_d;
      op_data_q   <= op_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      temp_q      <= temp_d;
      hum_q       <= hum_d;
      retry_q     <= retry_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      rxbuf_q     <= rxbuf_d;
      nack_code_q <= nack_code_d;
      nack_rd_q   <= nack_rd_d;
`ifdef SHT40_CRC_CHECK_EN
      crc_t_q     <= crc_t_d;
      crc_h_q     <= crc_h_d;
      crc_cnt_q   <= crc_cnt_d;
`endif
    end
  end

  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Err          = err_q;
  assign Err_Code     = err_code_q;
  assign Temp_Raw     = temp_q;
  assign Hum_Raw      = hum_q;
  assign bus.Op_Valid = op_valid_q;
  assign bus.Op_Code  = op_code_q;
  assign bus.Op_Data  = op_data_q;

endmodule

// File: tb/tb_sht40_measure_ctrl.sv
// Directed bench for sht40_measure_ctrl with a scripted I2C byte-engine responder.
module tb_sht40_measure_ctrl;
  localparam int W = 20;

  logic        clk = 1'b0, rst_n = 1'b0, Meas_Start = 1'b0;
  logic        Busy, Done, Err;
  logic [1:0]  Err_Code;
  logic [15:0] Temp_Raw, Hum_Raw;

  sht40_measure_ctrl_if bus();

  sht40_measure_ctrl #(.WAIT_CYCLES(W), .RETRY_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n), .Meas_Start(Meas_Start),
    .Busy(Busy), .Done(Done), .Err(Err), .Err_Code(Err_Code),
    .Temp_Raw(Temp_Raw), .Hum_Raw(Hum_Raw), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC-8 (poly 0x31, init 0xFF), byte-wise formulation.
  function automatic logic [7:0] crc8(input logic [15:0] w);
    logic [7:0] c;
    c = 8'hFF;
    for (int b = 1; b >= 0; b--) begin
      c = c ^ ((b == 1) ? w[15:8] : w[7:0]);
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  // Engine responder: answers each op on its second low-phase with Op_Valid high.
  logic [7:0]  rx [6];
  int          rd_idx = 0, w_nack = 0, r_nack = 0;
  logic [10:0] ops[$];
  int          cyc = 0, last_stop = 0, last_gap = -1, stab_err = 0, lat = 0;
  logic        prev_v = 1'b0;
  logic [2:0]  prev_code = 3'd0;
  logic [7:0]  prev_data = 8'd0;

  initial begin
    bus.Op_Done = 1'b0; bus.Op_Nack = 1'b0; bus.Op_Rx_Data = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      bus.Op_Done = 1'b0; bus.Op_Nack = 1'b0; bus.Op_Rx_Data = 8'h00;
      if (bus.Op_Valid && prev_v && (bus.Op_Code !== prev_code || bus.Op_Data !== prev_data))
        stab_err++;
      if (bus.Op_Valid && !prev_v && bus.Op_Code == 3'd0) last_gap = cyc - last_stop;
      prev_v = bus.Op_Valid; prev_code = bus.Op_Code; prev_data = bus.Op_Data;
      if (!bus.Op_Valid) lat = 0;
      else if (lat < 1) lat++;
      else begin
        lat = 0;
        bus.Op_Done = 1'b1;
        if (bus.Op_Code == 3'd1) begin
          ops.push_back({3'd1, bus.Op_Data});
          if (bus.Op_Data == 8'h88 && w_nack > 0) begin
            w_nack--; bus.Op_Nack = 1'b1;
          end else if (bus.Op_Data == 8'h89) begin
            if (r_nack > 0) begin r_nack--; bus.Op_Nack = 1'b1; end
            else rd_idx = 0;
          end
        end else begin
          ops.push_back({bus.Op_Code, 8'h00});
          if (bus.Op_Code == 3'd4) last_stop = cyc;
          if ((bus.Op_Code == 3'd2 || bus.Op_Code == 3'd3) && rd_idx < 6) begin
            bus.Op_Rx_Data = rx[rd_idx];
            rd_idx++;
          end
        end
      end
    end
  end

  logic [10:0] exp_ops[$];
  task automatic exp_write_phase();
    exp_ops.push_back(11'h000); exp_ops.push_back(11'h188);
    exp_ops.push_back(11'h1FD); exp_ops.push_back(11'h400);
  endtask
  task automatic exp_read_phase();
    exp_ops.push_back(11'h000); exp_ops.push_back(11'h189);
    for (int i = 0; i < 5; i++) exp_ops.push_back(11'h200);
    exp_ops.push_back(11'h300); exp_ops.push_back(11'h400);
  endtask
  task automatic cmp_ops(input string tag);
    int n;
    chk({tag, " op count"}, ops.size(), exp_ops.size());
    n = (ops.size() < exp_ops.size()) ? ops.size() : exp_ops.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s op%0d", tag, i), ops[i], exp_ops[i]);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_rx(input logic [15:0] t, input logic [7:0] tc,
                        input logic [15:0] h, input logic [7:0] hc);
    rx[0] = t[15:8]; rx[1] = t[7:0]; rx[2] = tc;
    rx[3] = h[15:8]; rx[4] = h[7:0]; rx[5] = hc;
  endtask

  task automatic start(input string tag);
    ops.delete(); exp_ops.delete();
    Meas_Start = 1'b1; tick(); Meas_Start = 1'b0;
    chk({tag, " busy after start"}, Busy, 1'b1);
  endtask

  // Waits for Done/Err; pokes Meas_Start in that cycle, which must be ignored.
  task automatic wait_end(input string tag, output logic d, output logic e);
    d = 1'b0; e = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (Done || Err) begin d = Done; e = Err; break; end
    end
    chk({tag, " end reached"}, d | e, 1'b1);
    chk({tag, " busy at end"}, Busy, 1'b0);
    Meas_Start = 1'b1; tick(); Meas_Start = 1'b0;
    chk({tag, " start on end ignored"}, Busy, 1'b0);
  endtask

  logic d, e, found;

  initial begin
    // Reset
    repeat (3) tick();
    chk("rst busy", Busy, 1'b0);     chk("rst done", Done, 1'b0);
    chk("rst err", Err, 1'b0);       chk("rst errcode", Err_Code, 2'b00);
    chk("rst temp", Temp_Raw, 16'h0); chk("rst hum", Hum_Raw, 16'h0);
    chk("rst opvalid", bus.Op_Valid, 1'b0);
    chk("rst opcode", bus.Op_Code, 3'b000); chk("rst opdata", bus.Op_Data, 8'h00);
    rst_n = 1'b1; tick();

    // Nominal
    set_rx(16'h66D5, crc8(16'h66D5), 16'h8A3C, crc8(16'h8A3C));
    start("nom"); wait_end("nom", d, e);
    chk("nom done", d, 1'b1); chk("nom err", e, 1'b0);
    chk("nom temp", Temp_Raw, 16'h66D5); chk("nom hum", Hum_Raw, 16'h8A3C);
    chk("nom errcode", Err_Code, 2'b00);
    // STOP Op_Done cycle to first START valid: W wait cycles + 1 idle + the rise itself.
    chk("nom wait gap", last_gap, W + 2);
    exp_write_phase(); exp_read_phase(); cmp_ops("nom");

    // Address NACK on every attempt
    w_nack = 3;
    start("anack"); wait_end("anack", d, e);
    chk("anack err", e, 1'b1); chk("anack done", d, 1'b0);
    chk("anack errcode", Err_Code, 2'b01);
    chk("anack temp kept", Temp_Raw, 16'h66D5); chk("anack hum kept", Hum_Raw, 16'h8A3C);
    chk("anack retry gap", last_gap, 2);
    for (int i = 0; i < 3; i++) begin
      exp_ops.push_back(11'h000); exp_ops.push_back(11'h188); exp_ops.push_back(11'h400);
    end
    cmp_ops("anack");

    // Bad temperature CRC
    set_rx(16'hBEEF, 8'h93, 16'hBEEF, 8'h92);
    start("badcrc"); wait_end("badcrc", d, e);
`ifdef SHT40_CRC_CHECK_EN
    chk("badcrc err", e, 1'b1); chk("badcrc errcode", Err_Code, 2'b11);
    chk("badcrc temp kept", Temp_Raw, 16'h66D5);
`else
    chk("badcrc done", d, 1'b1); chk("badcrc errcode", Err_Code, 2'b00);
    chk("badcrc temp", Temp_Raw, 16'hBEEF); chk("badcrc hum", Hum_Raw, 16'hBEEF);
`endif

    // Good CRC BE EF 92
    set_rx(16'hBEEF, 8'h92, 16'hBEEF, 8'h92);
    start("goodcrc"); wait_end("goodcrc", d, e);
    chk("goodcrc done", d, 1'b1); chk("goodcrc temp", Temp_Raw, 16'hBEEF);

    // Read-address NACK once, then ACK
    r_nack = 1;
    set_rx(16'h1234, crc8(16'h1234), 16'h5678, crc8(16'h5678));
    start("rnack"); wait_end("rnack", d, e);
    chk("rnack done", d, 1'b1); chk("rnack err", e, 1'b0);
    chk("rnack temp", Temp_Raw, 16'h1234); chk("rnack hum", Hum_Raw, 16'h5678);
    chk("rnack rewait gap", last_gap, W + 2);
    exp_write_phase();
    exp_ops.push_back(11'h000); exp_ops.push_back(11'h189); exp_ops.push_back(11'h400);
    exp_read_phase(); cmp_ops("rnack");

    // Reset while reading byte index 3
    set_rx(16'hA55A, crc8(16'hA55A), 16'h0FF0, crc8(16'h0FF0));
    start("midrst");
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rd_idx == 3 && bus.Op_Valid) begin found = 1'b1; break; end
      tick();
    end
    chk("midrst reached byte3", found, 1'b1);
    rst_n = 1'b0; tick();
    chk("midrst opvalid", bus.Op_Valid, 1'b0); chk("midrst busy", Busy, 1'b0);
    chk("midrst temp", Temp_Raw, 16'h0);
    rst_n = 1'b1; tick(); tick();
    start("post"); wait_end("post", d, e);
    chk("post done", d, 1'b1);
    chk("post temp", Temp_Raw, 16'hA55A); chk("post hum", Hum_Raw, 16'h0FF0);
    exp_write_phase(); exp_read_phase(); cmp_ops("post");

    chk("op held stable while valid", stab_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/sht40_measure_ctrl.md
Name: sht40_measure_ctrl

Overview:
Sequencer for one SHT40 high-precision measurement. It issues byte-level operations to the I2C master/SCL engine: START, address+W, command 0xFD, STOP, a 10 ms wait, START, address+R, six read bytes, STOP. It returns raw temperature and humidity words. It sits between the processor-side request logic and the I2C byte engine, and is the only requester of that engine.

Parameters:
DEV_ADDR, 7'h44, SHT40 7-bit address
MEAS_CMD, 8'hFD, measurement command byte
WAIT_CYCLES, 480000, clk cycles between write STOP and read START (10 ms at 48 MHz)
RETRY_MAX, 2, NACK retries before error

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous, active-low reset
Meas_Start  in  1  single-cycle pulse; ignored while Busy=1
Busy  out  1  high from accepted Meas_Start until Done or Err pulse
Done  out  1  one-cycle pulse, measurement valid
Err  out  1  one-cycle pulse, measurement aborted
Err_Code  out  2  01=addr NACK, 10=cmd NACK, 11=CRC fail; held until next accepted start
Temp_Raw  out  16  temperature word, MSB first on bus
Hum_Raw  out  16  humidity word
Op_Valid  out  1  operation request to byte engine
Op_Code  out  3  000 START, 001 WRITE, 010 READ_ACK, 011 READ_NACK, 100 STOP
Op_Data  out  8  byte for WRITE
Op_Done  in  1  engine one-cycle completion pulse
Op_Nack  in  1  valid with Op_Done on WRITE; 1 = slave NACK
Op_Rx_Data  in  8  valid with Op_Done on READ_*

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; Busy, Done, Err, Op_Valid = 0; Op_Code=000; Op_Data=0; Err_Code=00; Temp_Raw=Hum_Raw=0; retry and wait counters = 0. Reset mid-operation drops Op_Valid on the same edge. No STOP is issued; the engine resynchronises on its own.
- Handshake: Op_Valid, Op_Code and Op_Data are held stable until the cycle Op_Done=1. Op_Valid deasserts on the following edge. The next operation asserts no earlier than 1 cycle after that (minimum 1 idle cycle between ops). Op_Done while Op_Valid=0 is ignored.
- States: IDLE -> W_START -> W_ADDR (Op_Data={DEV_ADDR,0}) -> W_CMD (MEAS_CMD) -> W_STOP -> WAIT -> R_START -> R_ADDR ({DEV_ADDR,1}) -> R_BYTE -> R_STOP -> CHECK -> IDLE.
- IDLE: Meas_Start=1 sets Busy the next cycle, clears Err_Code and the retry count, and enters W_START.
- WAIT: counter loads 0 on entry and increments each cycle. Exit to R_START when the count equals WAIT_CYCLES-1, i.e. exactly WAIT_CYCLES cycles in WAIT. Counter width is $clog2(WAIT_CYCLES).
- R_BYTE: 3-bit index 0..5. Bytes 0-4 use READ_ACK; byte 5 uses READ_NACK. Bytes are stored into a 48-bit shift buffer in order: T_msb, T_lsb, T_crc, H_msb, H_lsb, H_crc.
- NACK on W_ADDR, W_CMD or R_ADDR: issue STOP, then:
  - if retries < RETRY_MAX: increment retries and restart at W_START. An R_ADDR NACK restarts at WAIT instead, because the sensor is still converting.
  - otherwise: pulse Err, set Err_Code (01 for either address phase, 10 for command), return to IDLE, Busy=0 on the same edge as the Err pulse.
- CHECK (1 cycle): load Temp_Raw and Hum_Raw from the buffer, pulse Done, Busy=0.
- Temp_Raw and Hum_Raw are unchanged on any error path.
- Meas_Start coincident with the Done or Err cycle is ignored. Meas_Start is accepted only in IDLE with Busy=0.
- Retry counter width is $clog2(RETRY_MAX+1). RETRY_MAX=0 means no retries.

Optional Feature:
SHT40_CRC_CHECK_EN
- Defined: CHECK computes CRC-8 (poly 0x31, init 0xFF, no reflection, no final XOR) over each 16-bit word and compares it with the received CRC byte; the computation may take up to 16 cycles.
  - Any mismatch: pulse Err, Err_Code=11, outputs not updated, no retry.
  - Both match: Done as above.
- Not defined: CRC bytes are read and discarded, and CHECK completes in 1 cycle.

Test Plan:
- Nominal: Meas_Start, engine ACKs all writes, returns 66 D5 xx 8A 3C xx -> ops in exact order START, WRITE 0x88, WRITE 0xFD, STOP, (WAIT_CYCLES idle), START, WRITE 0x89, 5×READ_ACK, READ_NACK, STOP; Done pulse; Temp_Raw=16'h66D5, Hum_Raw=16'h8A3C.
- Wait length: WAIT_CYCLES=20 -> exactly 20 cycles from the cycle after the write STOP's Op_Done to the R_START Op_Valid assertion (+1 mandatory idle cycle accounted as specified).
- Address NACK: RETRY_MAX=2, Op_Nack=1 on every W_ADDR -> 3 address attempts, each followed by STOP; then Err pulse, Err_Code=01, Busy=0, Temp_Raw unchanged.
- R_ADDR NACK once, then ACK -> STOP, re-wait WAIT_CYCLES, re-read; Done with correct data, no Err.
- With SHT40_CRC_CHECK_EN:
  - BE EF 92 BE EF 92 -> Done.
  - BE EF 93 ... -> Err, Err_Code=11.
- Without SHT40_CRC_CHECK_EN: the same bad-CRC stimulus -> Done.
- rst_n=0 during R_BYTE index 3 -> Op_Valid=0, Busy=0 next edge. A new Meas_Start after release runs a full clean sequence.
